beam_thresh_loader: RTL and testbench

//  Initiator side of the beamformer threshold-load protocol (thresh_i/thresh_wr_i/thresh_update_i).

---
 rtl/pueo_thresh_pkg.sv | 16 +
 rtl/thresh_ram.sv | 36 +++
 rtl/beam_thresh_loader.sv | 133 +++++++++++++
 tb/tb_beam_thresh_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pueo_thresh_pkg.sv
// Shared widths, threshold type and loader FSM states for the beam threshold-load path.
package pueo_thresh_pkg;

   localparam int unsigned THRESH_BITS = 18;
   localparam int unsigned NSETS       = 2;

   typedef logic [THRESH_BITS-1:0] thresh_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      UPDATE,
      DONE
   } state_t;

endpackage

// File: rtl/thresh_ram.sv
// Per-set, per-beam threshold store: one host write port, one registered read port.
module thresh_ram
   import pueo_thresh_pkg::*;
#(
   parameter int unsigned NBEAMS      = 48,
   parameter thresh_t     INIT_THRESH = 18'h3FFFF
) (
   input  logic                          clk_i,
   input  logic                          we_i,
   input  logic                          wsel_i,
   input  logic [$clog2(NBEAMS)-1:0]     waddr_i,
   input  logic [THRESH_BITS-1:0]        wdata_i,
   input  logic [$clog2(NBEAMS)-1:0]     raddr_i,
   output logic [NSETS*THRESH_BITS-1:0]  rdata_o
);

   // Power-up content only; reset never touches the array.
   thresh_t mem [NSETS][NBEAMS] = '{default: INIT_THRESH};
   thresh_t rd_q [NSETS];

   // Same-address write is forwarded so a read in the write cycle sees the new value.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[wsel_i][waddr_i] <= wdata_i;
      end
      for (int s = 0; s < NSETS; s++) begin
         rd_q[s] <= (we_i && (wsel_i == 1'(s)) && (waddr_i == raddr_i)) ? wdata_i
                                                                         : mem[s][raddr_i];
      end
   end

   for (genvar s = 0; s < NSETS; s++) begin : g_rd
      assign rdata_o[s*THRESH_BITS +: THRESH_BITS] = rd_q[s];
   end

endmodule

// File: rtl/beam_thresh_loader.sv
// Shifts stored per-beam thresholds into the beam cascade (last beam first) and then
// pulses a per-set update so all beams switch thresholds on the same clock.
module beam_thresh_loader
   import pueo_thresh_pkg::*;
#(
   parameter int unsigned NBEAMS      = 48,
   parameter thresh_t     INIT_THRESH = 18'h3FFFF
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [$clog2(NBEAMS)-1:0]     thr_addr_i,
   input  logic                          thr_sel_i,
   input  logic [THRESH_BITS-1:0]        thr_dat_i,
   input  logic                          thr_wr_i,
   output logic                          thr_ready_o,
   input  logic [NSETS-1:0]              load_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [NSETS*THRESH_BITS-1:0]  thresh_o,
   output logic [NSETS-1:0]              thresh_wr_o,
   output logic [NSETS-1:0]              thresh_update_o
);

   localparam int unsigned AW = $clog2(NBEAMS);
   localparam int unsigned DW = NSETS * THRESH_BITS;
   localparam logic [AW-1:0] LAST_BEAM = AW'(NBEAMS - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [NSETS-1:0] mask_q, mask_d;
   logic [AW-1:0]    rd_addr;
   logic [DW-1:0]    rdata;
   logic [DW-1:0]    set_mask;
   logic             ram_we;
   logic             busy_d;
   logic             done_d;
   logic [DW-1:0]    thresh_d;
   logic [NSETS-1:0] thresh_wr_d;
   logic [NSETS-1:0] thresh_update_d;

   assign ram_we = thr_wr_i & thr_ready_o & (32'(thr_addr_i) < NBEAMS);

   thresh_ram #(
      .NBEAMS      (NBEAMS),
      .INIT_THRESH (INIT_THRESH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .wsel_i  (thr_sel_i),
      .waddr_i (thr_addr_i),
      .wdata_i (thr_dat_i),
      .raddr_i (rd_addr),
      .rdata_o (rdata)
   );

   // Unselected set's data half is forced to zero.
   always_comb begin
      set_mask = '0;
      for (int s = 0; s < NSETS; s++) begin
         set_mask[s*THRESH_BITS +: THRESH_BITS] = {THRESH_BITS{mask_q[s]}};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         mask_q          <= '0;
         busy_o          <= 1'b0;
         thr_ready_o     <= 1'b1;
         done_o          <= 1'b0;
         thresh_o        <= '0;
         thresh_wr_o     <= '0;
         thresh_update_o <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         mask_q          <= mask_d;
         busy_o          <= busy_d;
         thr_ready_o     <= ~busy_d;
         done_o          <= done_d;
         thresh_o        <= thresh_d;
         thresh_wr_o     <= thresh_wr_d;
         thresh_update_o <= thresh_update_d;
      end
   end

   // Read address always runs one beam ahead of the strobe being registered.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      mask_d          = mask_q;
      rd_addr         = '0;
      done_d          = 1'b0;
      thresh_d        = '0;
      thresh_wr_d     = '0;
      thresh_update_d = '0;

      case (state_q)
         IDLE: begin
            rd_addr = LAST_BEAM;
            if ((load_i != '0) && !busy_o) begin
               mask_d  = load_i;
               idx_d   = LAST_BEAM;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            thresh_wr_d = mask_q;
            thresh_d    = rdata & set_mask;
            idx_d       = idx_q - AW'(1);
            if (idx_q != '0) begin
               rd_addr = idx_q - AW'(1);
            end else begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            thresh_update_d = mask_q;
            state_d         = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Busy stays up through the done pulse.
      busy_d = (state_d != IDLE) || (state_q == DONE);
   end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader: cycle-offset expectations plus a cascade scoreboard.
module tb_beam_thresh_loader;

   localparam int NB = 48;
   localparam int TB = 18;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [5:0]    thr_addr_i = '0;
   logic          thr_sel_i = 1'b0;
   logic [TB-1:0] thr_dat_i = '0;
   logic          thr_wr_i = 1'b0;
   logic [1:0]    load_i = '0;
   logic          thr_ready_o;
   logic          busy_o;
   logic          done_o;
   logic [2*TB-1:0] thresh_o;
   logic [1:0]    thresh_wr_o;
   logic [1:0]    thresh_update_o;

   int checks = 0;
   int errors = 0;

   logic [TB-1:0] ram_m [2][NB];
   logic [TB-1:0] casc  [2][NB];
   int            scnt [2];
   int            ucnt [2];
   int            k = -1;
   logic [1:0]    m = '0;

   always #5 clk = ~clk;

   beam_thresh_loader dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .thr_addr_i      (thr_addr_i),
      .thr_sel_i       (thr_sel_i),
      .thr_dat_i       (thr_dat_i),
      .thr_wr_i        (thr_wr_i),
      .thr_ready_o     (thr_ready_o),
      .load_i          (load_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .thresh_o        (thresh_o),
      .thresh_wr_o     (thresh_wr_o),
      .thresh_update_o (thresh_update_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: apply model effects of current inputs, advance, compare all outputs.
   task automatic step();
      int         kn;
      logic [42:0] e;
      logic [42:0] o;
      logic        ok;
      if (rst_i) begin
         kn      = -1;
         scnt[0] = 0;
         scnt[1] = 0;
      end else if (k < 0) begin
         kn = -1;
         if (thr_wr_i && (thr_addr_i < NB)) ram_m[thr_sel_i][thr_addr_i] = thr_dat_i;
         if (load_i != 2'b00) begin
            kn = 1;
            m  = load_i;
         end
      end else begin
         kn = (k >= 51) ? -1 : k + 1;
      end
      @(posedge clk);
      #1;
      k = kn;

      e      = '0;
      e[42]  = (k >= 1);
      e[41]  = !(k >= 1);
      e[40]  = (k == 51);
      if (k >= 2 && k <= 49) begin
         e[39:38] = m;
         for (int s = 0; s < 2; s++)
            if (m[s]) e[s*TB +: TB] = ram_m[s][49-k];
      end
      if (k == 50) e[37:36] = m;
      o = {busy_o, thr_ready_o, done_o, thresh_wr_o, thresh_update_o, thresh_o};
      chk($sformatf("outputs k=%0d", k), 64'(o), 64'(e));

      for (int s = 0; s < 2; s++) begin
         if (thresh_wr_o[s]) begin
            for (int i = NB-1; i > 0; i--) casc[s][i] = casc[s][i-1];
            casc[s][0] = thresh_o[s*TB +: TB];
            scnt[s]++;
         end
         if (thresh_update_o[s]) begin
            ok = (scnt[s] == NB);
            for (int i = 0; i < NB; i++)
               if (casc[s][i] !== ram_m[s][i]) ok = 1'b0;
            chk($sformatf("cascade set%0d", s), 64'(ok), 64'(1));
            ucnt[s]++;
            scnt[s] = 0;
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         scnt[s] = 0;
         ucnt[s] = 0;
         for (int i = 0; i < NB; i++) begin
            ram_m[s][i] = 18'h3FFFF;
            casc[s][i]  = '0;
         end
      end

      // Reset, then idle with load_i=00.
      repeat (3) step();
      rst_i = 1'b0;
      repeat (2) step();

      // Power-up content into both sets.
      load_i = 2'b11;
      step();
      load_i = 2'b00;
      repeat (54) step();

      // Host writes set0 beam b = b+100, plus one out-of-range address.
      thr_wr_i  = 1'b1;
      thr_sel_i = 1'b0;
      for (int b = 0; b < NB; b++) begin
         thr_addr_i = 6'(b);
         thr_dat_i  = 18'(b + 100);
         step();
      end
      thr_addr_i = 6'd48;
      thr_dat_i  = 18'd7;
      step();
      thr_wr_i = 1'b0;

      // Set0-only load.
      load_i = 2'b01;
      step();
      load_i = 2'b00;
      repeat (54) step();

      // Set1 load with re-requests and a host write while busy.
      load_i = 2'b10;
      step();
      for (int i = 1; i <= 54; i++) begin
         load_i = (i == 5 || i == 30) ? 2'b10 : 2'b00;
         if (i == 10) begin
            thr_wr_i   = 1'b1;
            thr_sel_i  = 1'b0;
            thr_addr_i = 6'd3;
            thr_dat_i  = 18'h55;
         end else begin
            thr_wr_i = 1'b0;
         end
         step();
      end
      load_i = 2'b00;
      chk("updates set1 after busy loads", 64'(ucnt[1]), 64'(2));
      chk("updates set0 after busy loads", 64'(ucnt[0]), 64'(2));

      // Write to the first-read beam in the same cycle as the load.
      thr_wr_i   = 1'b1;
      thr_sel_i  = 1'b0;
      thr_addr_i = 6'd47;
      thr_dat_i  = 18'h2AAAA;
      load_i     = 2'b01;
      step();
      thr_wr_i = 1'b0;
      load_i   = 2'b00;
      repeat (54) step();
      chk("updates set0 after same-cycle write", 64'(ucnt[0]), 64'(3));

      // Reset at T+20 of a load: abort with no update.
      load_i = 2'b11;
      step();
      load_i = 2'b00;
      repeat (19) step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      repeat (5) step();
      chk("updates set0 after abort", 64'(ucnt[0]), 64'(3));
      chk("updates set1 after abort", 64'(ucnt[1]), 64'(2));

      // Following load completes normally.
      load_i = 2'b11;
      step();
      load_i = 2'b00;
      repeat (54) step();
      chk("updates set0 final", 64'(ucnt[0]), 64'(4));
      chk("updates set1 final", 64'(ucnt[1]), 64'(3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
